// File: rtl/escalonador_jogo_pkg.sv
// -----------------------------------------------------------------------------
// escalonador_jogo_pkg
// Shared definitions for the game-tick scheduler: FSM state encodings (also the
// db_estado codes shown on the hexa7seg display), difficulty mode codes, speed
// level width and the effective-period helper used by the top.
// -----------------------------------------------------------------------------
package escalonador_jogo_pkg;

  typedef enum logic [3:0] {
    PARADO   = 4'd0,
    CONTANDO = 4'd1,
    PAUSADO  = 4'd2,
    ESGOTADO = 4'd3
  } estado_t;

  localparam logic [1:0] MODO_FACIL  = 2'd0;  // base period << 2
  localparam logic [1:0] MODO_MEDIO  = 2'd1;  // base period << 1
  localparam logic [1:0] MODO_BASE   = 2'd2;  // base period
  localparam logic [1:0] MODO_RAPIDO = 2'd3;  // base period >> 1

  localparam int NIVEL_W = 2;

  // Map-step period in clock cycles for a given mode and speed level.
  // Floored at 2 so tick_mapa can never be high on two consecutive cycles.
  function automatic int unsigned periodo_efetivo(input int unsigned       base,
                                                  input logic [1:0]        modo,
                                                  input logic [NIVEL_W-1:0] nivel);
    int unsigned p;
    case (modo)
      MODO_FACIL:  p = base << 2;
      MODO_MEDIO:  p = base << 1;
      MODO_BASE:   p = base;
      default:     p = base >> 1;
    endcase
    p = p >> nivel;
    if (p < 2) p = 2;
    return p;
  endfunction

endpackage

// File: rtl/escalonador_jogo_contador_limite.sv
// -----------------------------------------------------------------------------
// escalonador_jogo_contador_limite
// Wrapping counter with synchronous clear and a terminal-count flag.
//   clock  in        rising-edge clock
//   reset  in        asynchronous active-low reset
//   en     in        count enable
//   clr    in        synchronous clear (wins over en)
//   limite in  [W]   last value before wrapping to 0
//   fim    out       high while the count equals limite
// -----------------------------------------------------------------------------
module escalonador_jogo_contador_limite #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == limite) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign fim = (cnt_q == limite);

endmodule

// File: rtl/escalonador_jogo.sv
// -----------------------------------------------------------------------------
// escalonador_jogo
// Game-tick scheduler: emits the periodic map-advance pulse at a rate chosen by
// the difficulty mode and raises timeout after a long stretch without moves.
// Optional feature macro: ACELERACAO_EN (speed levels that shorten the period
// every PASSOS_NIVEL map steps; without it nivel is tied to 0).
//   clock      in       rising-edge clock
//   reset      in       asynchronous active-low reset
//   zera       in       synchronous clear of all state
//   habilita   in       level, game running
//   pausa      in       level, freezes counting
//   modo       in  [2]  difficulty, latched on PARADO->CONTANDO
//   movimento  in       one-cycle pulse per accepted player move
//   tick_mapa  out      one-cycle registered pulse: advance map
//   timeout    out      high while in ESGOTADO
//   nivel      out [2]  current speed level
//   db_estado  out [4]  state code for display
// -----------------------------------------------------------------------------
module escalonador_jogo
  import escalonador_jogo_pkg::*;
#(
  parameter int unsigned PERIODO_BASE   = 25_000_000,
  parameter int unsigned TIMEOUT_CICLOS = 250_000_000,
  parameter int unsigned PASSOS_NIVEL   = 8,
  parameter int unsigned NIVEL_MAX      = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zera,
  input  logic               habilita,
  input  logic               pausa,
  input  logic [1:0]         modo,
  input  logic               movimento,
  output logic               tick_mapa,
  output logic               timeout,
  output logic [NIVEL_W-1:0] nivel,
  output logic [3:0]         db_estado
);

  localparam int CW = ($clog2(PERIODO_BASE << 2) > 0) ? $clog2(PERIODO_BASE << 2) : 1;
  localparam int IW = ($clog2(TIMEOUT_CICLOS) > 0) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [IW-1:0] IDLE_LIM = IW'(TIMEOUT_CICLOS - 1);

  estado_t            estado_q, estado_d;
  logic [1:0]         modo_q, modo_d;
  logic               tick_q, tick_d;
  logic [NIVEL_W-1:0] nivel_atual;

  logic               ativo, mov_ok, limpa;
  logic               tick_fim, idle_fim;
  logic               tick_evt, timeout_evt;
  logic [CW-1:0]      tick_lim;

  // Counting happens in CONTANDO and also in the PAUSADO cycle where pausa has
  // dropped, so a tick held back by a pause comes out on the first cycle after.
  assign ativo  = !zera && habilita && !pausa &&
                  ((estado_q == CONTANDO) || (estado_q == PAUSADO));
  assign mov_ok = ativo && movimento && (estado_q == CONTANDO);
  assign limpa  = zera || !habilita || (estado_q == PARADO);

  // A move on the last idle cycle clears the idle count instead of timing out;
  // the tick due on the timeout cycle is dropped since ESGOTADO never ticks.
  assign timeout_evt = ativo && idle_fim && !mov_ok;
  assign tick_evt    = ativo && tick_fim && !timeout_evt;

  assign tick_lim = CW'(periodo_efetivo(PERIODO_BASE, modo_q, nivel_atual) - 1);

  escalonador_jogo_contador_limite #(.W(CW)) u_cnt_tick (
    .clock  (clock),
    .reset  (reset),
    .en     (ativo),
    .clr    (limpa),
    .limite (tick_lim),
    .fim    (tick_fim)
  );

  escalonador_jogo_contador_limite #(.W(IW)) u_cnt_idle (
    .clock  (clock),
    .reset  (reset),
    .en     (ativo),
    .clr    (limpa || mov_ok),
    .limite (IDLE_LIM),
    .fim    (idle_fim)
  );

`ifdef ACELERACAO_EN
  localparam int SW = ($clog2(PASSOS_NIVEL) > 0) ? $clog2(PASSOS_NIVEL) : 1;

  logic [NIVEL_W-1:0] nivel_q, nivel_d;
  logic               passo_fim;

  escalonador_jogo_contador_limite #(.W(SW)) u_cnt_passo (
    .clock  (clock),
    .reset  (reset),
    .en     (tick_evt),
    .clr    (limpa),
    .limite (SW'(PASSOS_NIVEL - 1)),
    .fim    (passo_fim)
  );

  // The level changes on the same edge the tick counter wraps to 0, so the
  // shorter period starts cleanly with the next window. Kept across habilita=0.
  always_comb begin
    nivel_d = nivel_q;
    if (zera) begin
      nivel_d = '0;
    end else if (tick_evt && passo_fim && (32'(nivel_q) < NIVEL_MAX)) begin
      nivel_d = nivel_q + NIVEL_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) nivel_q <= '0;
    else        nivel_q <= nivel_d;
  end

  assign nivel_atual = nivel_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{PASSOS_NIVEL, NIVEL_MAX};
  assign nivel_atual = '0;
`endif

  // Priority: zera > habilita low > pausa > counting.
  always_comb begin
    estado_d = estado_q;
    modo_d   = modo_q;
    tick_d   = 1'b0;
    if (zera) begin
      estado_d = PARADO;
      modo_d   = '0;
    end else if (!habilita) begin
      estado_d = PARADO;
    end else begin
      case (estado_q)
        PARADO: begin
          estado_d = CONTANDO;
          modo_d   = modo;
        end
        CONTANDO, PAUSADO: begin
          if (pausa) begin
            estado_d = PAUSADO;
          end else if (timeout_evt) begin
            estado_d = ESGOTADO;
          end else begin
            estado_d = CONTANDO;
            tick_d   = tick_evt;
          end
        end
        ESGOTADO: estado_d = ESGOTADO;
        default:  estado_d = PARADO;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= PARADO;
      modo_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      modo_q   <= modo_d;
      tick_q   <= tick_d;
    end
  end

  assign tick_mapa = tick_q;
  assign timeout   = (estado_q == ESGOTADO);
  assign nivel     = nivel_atual;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_escalonador_jogo.sv
module tb_escalonador_jogo;

  localparam int unsigned PB = 4;
  localparam int unsigned TO = 20;
  localparam int unsigned PN = 2;
  localparam int unsigned NM = 3;
`ifdef ACELERACAO_EN
  localparam bit ACEL = 1'b1;
`else
  localparam bit ACEL = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       zera = 1'b0;
  logic       habilita = 1'b0;
  logic       pausa = 1'b0;
  logic [1:0] modo = 2'd0;
  logic       movimento = 1'b0;
  logic       tick_mapa;
  logic       timeout;
  logic [1:0] nivel;
  logic [3:0] db_estado;

  int          n_checks = 0;
  int          n_erros = 0;
  int unsigned cyc = 0;
  int unsigned mov_periodo = 0;
  logic        tick_ant = 1'b0;

  escalonador_jogo #(
    .PERIODO_BASE   (PB),
    .TIMEOUT_CICLOS (TO),
    .PASSOS_NIVEL   (PN),
    .NIVEL_MAX      (NM)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .zera      (zera),
    .habilita  (habilita),
    .pausa     (pausa),
    .modo      (modo),
    .movimento (movimento),
    .tick_mapa (tick_mapa),
    .timeout   (timeout),
    .nivel     (nivel),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    n_checks++;
    if (obtido !== esperado) begin
      n_erros++;
      $display("FAIL %s: obtido=%0d esperado=%0d", tag, obtido, esperado);
    end
  endtask

  // One clock: sample #1 after the rising edge, then drive the next inputs.
  task automatic passo();
    @(posedge clock);
    #1;
    cyc++;
    verifica("tick_consecutivo", {31'd0, tick_mapa & tick_ant}, 32'd0);
    tick_ant = tick_mapa;
    if (mov_periodo != 0) movimento = ((cyc % mov_periodo) == 0);
  endtask

  task automatic espera_tick(input int maxc, output int n);
    bit achou;
    achou = 1'b0;
    n = 0;
    for (int i = 1; i <= maxc && !achou; i++) begin
      passo();
      if (tick_mapa === 1'b1) begin
        achou = 1'b1;
        n = i;
      end
    end
  endtask

  // zera for one cycle with habilita high; returns on the first CONTANDO cycle.
  task automatic reinicia(input logic [1:0] m);
    zera = 1'b1;
    habilita = 1'b1;
    pausa = 1'b0;
    modo = m;
    passo();
    zera = 1'b0;
    passo();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ticks_pausa;
    int esp_p[10];
    int esp_n[10];

    // ---- 1: reset ----
    habilita = 1'b1;
    modo = 2'd2;
    mov_periodo = 5;
    repeat (2) @(posedge clock);
    #1;
    verifica("rst_db_estado", {28'd0, db_estado}, 32'd0);
    verifica("rst_tick", {31'd0, tick_mapa}, 32'd0);
    reset = 1'b1;
    passo();
    verifica("pos_rst_contando", {28'd0, db_estado}, 32'd1);
    repeat (6) passo();
    reset = 1'b0;
    #1;
    verifica("rst_meio_tick", {31'd0, tick_mapa}, 32'd0);
    verifica("rst_meio_timeout", {31'd0, timeout}, 32'd0);
    verifica("rst_meio_nivel", {30'd0, nivel}, 32'd0);
    verifica("rst_meio_db", {28'd0, db_estado}, 32'd0);
    passo();
    passo();
    verifica("rst_mantido_db", {28'd0, db_estado}, 32'd0);
    reset = 1'b1;
    passo();
    verifica("rst_solto_contando", {28'd0, db_estado}, 32'd1);

    // ---- 2: period per mode, modo ignored mid-run ----
    mov_periodo = 10;
    reinicia(2'd0);
    espera_tick(40, n);
    verifica("modo0_primeiro", n, 16);
    espera_tick(40, n);
    verifica("modo0_segundo", n, 16);
    modo = 2'd3;
    espera_tick(40, n);
    verifica("modo0_troca_ignorada", n, ACEL ? 8 : 16);
    reinicia(2'd3);
    espera_tick(40, n);
    verifica("modo3_primeiro", n, 2);
    espera_tick(40, n);
    verifica("modo3_segundo", n, 2);
    reinicia(2'd1);
    espera_tick(40, n);
    verifica("modo1_primeiro", n, 8);

    // ---- 3: idle timeout ----
    mov_periodo = 0;
    movimento = 1'b0;
    reinicia(2'd2);
    repeat (19) passo();
    verifica("idle19_timeout", {31'd0, timeout}, 32'd0);
    verifica("idle19_db", {28'd0, db_estado}, 32'd1);
    passo();
    verifica("idle20_timeout", {31'd0, timeout}, 32'd1);
    verifica("idle20_db", {28'd0, db_estado}, 32'd3);
    verifica("idle20_tick_suprimido", {31'd0, tick_mapa}, 32'd0);
    repeat (4) passo();
    verifica("esgotado_mantido", {31'd0, timeout}, 32'd1);
    habilita = 1'b0;
    passo();
    verifica("esgotado_sai_db", {28'd0, db_estado}, 32'd0);
    verifica("esgotado_sai_timeout", {31'd0, timeout}, 32'd0);
    reinicia(2'd2);
    repeat (19) passo();
    movimento = 1'b1;
    passo();
    movimento = 1'b0;
    verifica("mov_ultimo_ciclo_timeout", {31'd0, timeout}, 32'd0);
    verifica("mov_ultimo_ciclo_db", {28'd0, db_estado}, 32'd1);
    repeat (19) passo();
    verifica("idle_reiniciado_19", {31'd0, timeout}, 32'd0);
    passo();
    verifica("idle_reiniciado_20", {31'd0, timeout}, 32'd1);

    // ---- 4: pause at cnt_tick=3 ----
    reinicia(2'd2);
    repeat (3) passo();
    verifica("pre_pausa_tick", {31'd0, tick_mapa}, 32'd0);
    pausa = 1'b1;
    ticks_pausa = 0;
    passo();
    verifica("pausado_db", {28'd0, db_estado}, 32'd2);
    if (tick_mapa === 1'b1) ticks_pausa++;
    repeat (6) begin
      passo();
      if (tick_mapa === 1'b1) ticks_pausa++;
    end
    verifica("pausa_sem_tick", ticks_pausa, 0);
    pausa = 1'b0;
    passo();
    verifica("retoma_tick", {31'd0, tick_mapa}, 32'd1);
    verifica("retoma_db", {28'd0, db_estado}, 32'd1);
    espera_tick(40, n);
    verifica("retoma_periodo", n, 4);

`ifdef ACELERACAO_EN
    // ---- 5: speed levels ----
    esp_p = '{16, 16, 8, 8, 4, 4, 2, 2, 2, 2};
    esp_n = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3};
    mov_periodo = 10;
    reinicia(2'd0);
    for (int k = 0; k < 10; k++) begin
      espera_tick(40, n);
      verifica($sformatf("acel_periodo_%0d", k), n, esp_p[k]);
      verifica($sformatf("acel_nivel_%0d", k), {30'd0, nivel}, esp_n[k]);
    end
    zera = 1'b1;
    passo();
    zera = 1'b0;
    verifica("acel_zera_nivel", {30'd0, nivel}, 32'd0);
`else
    esp_p = '{default: 0};
    esp_n = '{default: 0};
    verifica("nivel_fixo", {30'd0, nivel}, 32'd0);
`endif

    // ---- 6: zera with habilita and movimento ----
    mov_periodo = 0;
    reinicia(2'd2);
    repeat (5) passo();
    zera = 1'b1;
    movimento = 1'b1;
    passo();
    verifica("zera_db", {28'd0, db_estado}, 32'd0);
    verifica("zera_tick", {31'd0, tick_mapa}, 32'd0);
    zera = 1'b0;
    movimento = 1'b0;
    passo();
    verifica("zera_reentra_db", {28'd0, db_estado}, 32'd1);
    espera_tick(40, n);
    verifica("zera_cnt_tick_limpo", n, 4);
    repeat (15) passo();
    verifica("zera_idle_19", {31'd0, timeout}, 32'd0);
    passo();
    verifica("zera_idle_20", {31'd0, timeout}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
    $finish;
  end

endmodule
